// File: rtl/wb_dest_tracker_pkg.sv
// ----------------------------------------------------------------------------
// wb_dest_tracker_pkg
//   Shared constants and types for the write-back tag tracker.
//   - REGFILE_ADDRESS_LEN : register-file address width
//   - fwd_sel_e           : forwarding select codes (REG / MEM / WB)
//   - fwd_pick()          : MEM-over-WB forwarding priority
// ----------------------------------------------------------------------------
package wb_dest_tracker_pkg;

    localparam int REGFILE_ADDRESS_LEN = 4;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    // The younger result (MEM) is the architecturally correct one when both
    // stages hold the same destination, so it wins.
    function automatic fwd_sel_e fwd_pick(input logic mem_hit, input logic wb_hit);
        if (mem_hit)     return FWD_MEM;
        else if (wb_hit) return FWD_WB;
        else             return FWD_REG;
    endfunction

endpackage

// File: rtl/wb_dest_tracker_pipe_tag_stage.sv
// ----------------------------------------------------------------------------
// pipe_tag_stage
//   One pipeline stage register holding a write-back tag
//   {valid, dest, wb_en, mem_read}.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     hold              keep the current contents (highest priority)
//     bubble            load an empty tag instead of the d_* inputs
//     d_valid/d_dest/d_wb_en/d_mem_read   incoming tag
//     q_valid/q_dest/q_wb_en/q_mem_read   stored tag
//   An invalid tag is always stored fully zeroed, so a bubble reads dest=0.
// ----------------------------------------------------------------------------
module pipe_tag_stage #(
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hold,
    input  logic                  bubble,
    input  logic                  d_valid,
    input  logic [REG_ADDR_W-1:0] d_dest,
    input  logic                  d_wb_en,
    input  logic                  d_mem_read,
    output logic                  q_valid,
    output logic [REG_ADDR_W-1:0] q_dest,
    output logic                  q_wb_en,
    output logic                  q_mem_read
);

    logic load_tag;
    assign load_tag = d_valid & ~bubble;

    // NOTE: state registers use non-blocking assignments so every stage
    // samples its neighbour's pre-edge value; the async reset clears the
    // whole tag so an in-flight instruction cannot survive a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid    <= 1'b0;
            q_dest     <= '0;
            q_wb_en    <= 1'b0;
            q_mem_read <= 1'b0;
        end else if (!hold) begin
            q_valid    <= load_tag;
            q_dest     <= load_tag ? d_dest : '0;
            q_wb_en    <= load_tag & d_wb_en;
            q_mem_read <= load_tag & d_mem_read;
        end
    end

endmodule

// File: rtl/wb_dest_tracker.sv
// ----------------------------------------------------------------------------
// wb_dest_tracker
//   Carries each issued instruction's write-back tag through EXE, MEM and WB,
//   drives the hazard detector's exe_*/mem_* inputs, generates forwarding
//   selects and counts hazard stall cycles.
//   Inputs : clk, rst_n, id_valid, id_dest, id_wb_en, id_mem_read,
//            src1, src2, two_src, fwd_en, hazard, flush, freeze, cnt_clr
//   Outputs: exe_wb_dest, exe_wb_enable, exe_mem_read_en,
//            mem_wb_dest, mem_wb_enable, wb_dest, wb_enable,
//            fwd_sel1, fwd_sel2 (00 reg, 01 MEM, 10 WB), stall_count
// ----------------------------------------------------------------------------
module wb_dest_tracker
    import wb_dest_tracker_pkg::*;
#(
    parameter int REG_ADDR_W = REGFILE_ADDRESS_LEN,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_wb_en,
    input  logic                  id_mem_read,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic                  two_src,
    input  logic                  fwd_en,
    input  logic                  hazard,
    input  logic                  flush,
    input  logic                  freeze,
    input  logic                  cnt_clr,
    output logic [REG_ADDR_W-1:0] exe_wb_dest,
    output logic                  exe_wb_enable,
    output logic                  exe_mem_read_en,
    output logic [REG_ADDR_W-1:0] mem_wb_dest,
    output logic                  mem_wb_enable,
    output logic [REG_ADDR_W-1:0] wb_dest,
    output logic                  wb_enable,
    output logic [1:0]            fwd_sel1,
    output logic [1:0]            fwd_sel2,
    output logic [CNT_W-1:0]      stall_count
);

    logic                  exe_valid, exe_wb_en, exe_mem_read;
    logic [REG_ADDR_W-1:0] exe_dest;
    logic                  mem_valid, mem_wb_en, mem_mem_read;
    logic [REG_ADDR_W-1:0] mem_dest;
    logic                  wb_valid, wb_wb_en, wb_mem_read;
    logic [REG_ADDR_W-1:0] wb_dest_q;

    // A stalled or flushed ID instruction must not enter EXE; one bubble is
    // injected per hazard cycle while ID/IF hold outside this block.
    logic exe_bubble;
    assign exe_bubble = hazard | flush;

    pipe_tag_stage #(.REG_ADDR_W(REG_ADDR_W)) u_exe (
        .clk(clk), .rst_n(rst_n), .hold(freeze), .bubble(exe_bubble),
        .d_valid(id_valid), .d_dest(id_dest), .d_wb_en(id_wb_en), .d_mem_read(id_mem_read),
        .q_valid(exe_valid), .q_dest(exe_dest), .q_wb_en(exe_wb_en), .q_mem_read(exe_mem_read)
    );

    pipe_tag_stage #(.REG_ADDR_W(REG_ADDR_W)) u_mem (
        .clk(clk), .rst_n(rst_n), .hold(freeze), .bubble(1'b0),
        .d_valid(exe_valid), .d_dest(exe_dest), .d_wb_en(exe_wb_en), .d_mem_read(exe_mem_read),
        .q_valid(mem_valid), .q_dest(mem_dest), .q_wb_en(mem_wb_en), .q_mem_read(mem_mem_read)
    );

    pipe_tag_stage #(.REG_ADDR_W(REG_ADDR_W)) u_wb (
        .clk(clk), .rst_n(rst_n), .hold(freeze), .bubble(1'b0),
        .d_valid(mem_valid), .d_dest(mem_dest), .d_wb_en(mem_wb_en), .d_mem_read(mem_mem_read),
        .q_valid(wb_valid), .q_dest(wb_dest_q), .q_wb_en(wb_wb_en), .q_mem_read(wb_mem_read)
    );

    // Stage registers already zero dest/enables for bubbles; the valid gating
    // keeps the enables honest even if that invariant were ever relaxed.
    assign exe_wb_dest     = exe_dest;
    assign exe_wb_enable   = exe_valid & exe_wb_en;
    assign exe_mem_read_en = exe_valid & exe_mem_read;
    assign mem_wb_dest     = mem_dest;
    assign mem_wb_enable   = mem_valid & mem_wb_en;
    assign wb_dest         = wb_dest_q;
    assign wb_enable       = wb_valid & wb_wb_en;

    logic mem_hit1, wb_hit1, mem_hit2, wb_hit2;

    // NOTE: every combinational output gets a default-free full assignment
    // here (continuous assigns), so no path can infer a latch.
    assign mem_hit1 = fwd_en & mem_wb_enable & (mem_wb_dest == src1);
    assign wb_hit1  = fwd_en & wb_enable     & (wb_dest_q   == src1);
    assign mem_hit2 = fwd_en & two_src & mem_wb_enable & (mem_wb_dest == src2);
    assign wb_hit2  = fwd_en & two_src & wb_enable     & (wb_dest_q   == src2);

    assign fwd_sel1 = fwd_pick(mem_hit1, wb_hit1);
    assign fwd_sel2 = fwd_pick(mem_hit2, wb_hit2);

    // Stall counter: clear beats increment; a frozen pipeline is not a
    // hazard stall, so counting pauses while freeze is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (cnt_clr) begin
            stall_count <= '0;
        end else if (hazard && !freeze && !(&stall_count)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_dest_tracker.sv
// ----------------------------------------------------------------------------
// tb_wb_dest_tracker
//   Directed bench for wb_dest_tracker (CNT_W=4 so saturation is reachable).
// ----------------------------------------------------------------------------
module tb_wb_dest_tracker;

    localparam int AW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid, id_wb_en, id_mem_read;
    logic [AW-1:0] id_dest, src1, src2;
    logic          two_src, fwd_en, hazard, flush, freeze, cnt_clr;
    logic [AW-1:0] exe_wb_dest, mem_wb_dest, wb_dest;
    logic          exe_wb_enable, exe_mem_read_en, mem_wb_enable, wb_enable;
    logic [1:0]    fwd_sel1, fwd_sel2;
    logic [CW-1:0] stall_count;

    int n_checks = 0;
    int n_passed = 0;

    always #5 clk = ~clk;

    wb_dest_tracker #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
        .src1(src1), .src2(src2), .two_src(two_src), .fwd_en(fwd_en),
        .hazard(hazard), .flush(flush), .freeze(freeze), .cnt_clr(cnt_clr),
        .exe_wb_dest(exe_wb_dest), .exe_wb_enable(exe_wb_enable), .exe_mem_read_en(exe_mem_read_en),
        .mem_wb_dest(mem_wb_dest), .mem_wb_enable(mem_wb_enable),
        .wb_dest(wb_dest), .wb_enable(wb_enable),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall_count(stall_count)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Advance one rising edge, then settle before inputs change or checks run.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [AW-1:0] d, input logic we, input logic mr);
        id_valid = v; id_dest = d; id_wb_en = we; id_mem_read = mr;
    endtask

    initial begin
        rst_n = 1'b0;
        issue(1'b0, '0, 1'b0, 1'b0);
        src1 = '0; src2 = '0; two_src = 1'b0; fwd_en = 1'b0;
        hazard = 1'b0; flush = 1'b0; freeze = 1'b0; cnt_clr = 1'b0;

        // Reset state
        #12;
        check("rst_exe_en",  exe_wb_enable, 0);
        check("rst_mem_en",  mem_wb_enable, 0);
        check("rst_wb_en",   wb_enable, 0);
        check("rst_fwd1",    fwd_sel1, 0);
        check("rst_cnt",     stall_count, 0);
        rst_n = 1'b1;
        step();

        // Flow: dest=3 travels EXE -> MEM -> WB
        issue(1'b1, 4'd3, 1'b1, 1'b0);
        step();
        check("flow_exe_en",   exe_wb_enable, 1);
        check("flow_exe_dest", exe_wb_dest, 3);
        issue(1'b0, 4'd0, 1'b0, 1'b0);
        step();
        check("flow_exe_bub",  exe_wb_enable, 0);
        check("flow_exe_bdst", exe_wb_dest, 0);
        check("flow_mem_en",   mem_wb_enable, 1);
        check("flow_mem_dest", mem_wb_dest, 3);
        step();
        check("flow_wb_en",    wb_enable, 1);
        check("flow_wb_dest",  wb_dest, 3);
        check("flow_mem_gone", mem_wb_enable, 0);

        // Load-use: load dest=5, then one hazard cycle injects a bubble
        issue(1'b1, 4'd5, 1'b1, 1'b1);
        step();
        check("ld_exe_mr",    exe_mem_read_en, 1);
        check("ld_exe_dest",  exe_wb_dest, 5);
        issue(1'b1, 4'd6, 1'b1, 1'b0);
        hazard = 1'b1;
        step();
        check("ld_bub_en",    exe_wb_enable, 0);
        check("ld_bub_mr",    exe_mem_read_en, 0);
        check("ld_mem_dest",  mem_wb_dest, 5);
        check("ld_cnt",       stall_count, 1);
        hazard = 1'b0;
        step();
        check("ld_exe_6",     exe_wb_dest, 6);
        check("ld_mem_bub",   mem_wb_enable, 0);
        check("ld_wb_dest",   wb_dest, 5);

        // Freeze with hazard asserted: nothing moves, counter holds
        freeze = 1'b1; hazard = 1'b1;
        issue(1'b1, 4'd7, 1'b1, 1'b0);
        step(); step(); step();
        check("frz_exe_dest", exe_wb_dest, 6);
        check("frz_exe_en",   exe_wb_enable, 1);
        check("frz_mem_en",   mem_wb_enable, 0);
        check("frz_wb_dest",  wb_dest, 5);
        check("frz_wb_en",    wb_enable, 1);
        check("frz_cnt",      stall_count, 1);
        freeze = 1'b0; hazard = 1'b0;
        issue(1'b0, 4'd0, 1'b0, 1'b0);

        // Mid-stream async reset clears everything at once
        rst_n = 1'b0;
        #1;
        check("mrst_exe_en",  exe_wb_enable, 0);
        check("mrst_exe_dst", exe_wb_dest, 0);
        check("mrst_wb_en",   wb_enable, 0);
        check("mrst_cnt",     stall_count, 0);
        step();
        rst_n = 1'b1;

        // Forwarding: dest=2 in both MEM and WB
        issue(1'b1, 4'd2, 1'b1, 1'b0);
        step(); step();
        issue(1'b0, 4'd0, 1'b0, 1'b0);
        step();
        src1 = 4'd2; src2 = 4'd2; fwd_en = 1'b1; two_src = 1'b0;
        #1;
        check("fwd_both_mem", fwd_sel1, 2'b01);
        check("fwd_2_nosrc",  fwd_sel2, 2'b00);
        two_src = 1'b1;
        #1;
        check("fwd_2_mem",    fwd_sel2, 2'b01);
        fwd_en = 1'b0;
        #1;
        check("fwd_off1",     fwd_sel1, 2'b00);
        check("fwd_off2",     fwd_sel2, 2'b00);
        fwd_en = 1'b1;
        step();
        check("fwd_wb_only",  fwd_sel1, 2'b10);
        src1 = 4'd3;
        #1;
        check("fwd_nomatch",  fwd_sel1, 2'b00);
        fwd_en = 1'b0; two_src = 1'b0;

        // Valid non-writing tag keeps its dest but reports no enable
        issue(1'b1, 4'd9, 1'b0, 1'b0);
        step();
        check("nw_exe_dest",  exe_wb_dest, 9);
        check("nw_exe_en",    exe_wb_enable, 0);

        // Flush kills the ID instruction without counting a stall
        issue(1'b1, 4'd4, 1'b1, 1'b0);
        flush = 1'b1;
        step();
        check("fl_exe_en",    exe_wb_enable, 0);
        check("fl_exe_dest",  exe_wb_dest, 0);
        check("fl_cnt",       stall_count, 0);
        flush = 1'b0;
        issue(1'b0, 4'd0, 1'b0, 1'b0);

        // Saturation at 15, then clear beats increment
        hazard = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("sat_cnt",      stall_count, 15);
        cnt_clr = 1'b1;
        step();
        check("clr_cnt",      stall_count, 0);
        cnt_clr = 1'b0;
        step();
        check("post_clr_cnt", stall_count, 1);
        hazard = 1'b0;

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
